// File: rtl/ariane_pkg.sv
// Shared types for the commit stage: scoreboard entries, exceptions, fence kinds and FSM states.
// Also holds small decode helpers used by both the commit unit and its port-pairing check.
package ariane_pkg;

  typedef enum logic [2:0] {
    FU_NONE, FU_LOAD, FU_STORE, FU_ALU, FU_CTRL_FLOW, FU_MULT, FU_CSR, FU_FPU
  } fu_t;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_JAL, OP_LD, OP_FLD, OP_SD, OP_FSD,
    OP_FADD, OP_FMUL, OP_FCVT_L_D, OP_CSRRW, OP_CSRRS, OP_CSRRC,
    OP_FENCE, OP_FENCE_I, OP_SFENCE_VMA
  } fu_op;

  typedef enum logic [1:0] {FK_NONE, FK_FENCE, FK_FENCE_I, FK_SFENCE} fence_kind_t;

  typedef enum logic {ST_IDLE, ST_DRAIN} commit_state_e;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic [63:0] pc;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0] pc;
    fu_t         fu;
    fu_op        op;
    logic [4:0]  rd;
    logic [63:0] result;
    exception_t  ex;
    logic        valid;
  } scoreboard_entry_t;

  function automatic logic is_rd_fpr(fu_op op);
    return op inside {OP_FLD, OP_FADD, OP_FMUL};
  endfunction

  function automatic fence_kind_t fence_kind(fu_op op);
    case (op)
      OP_FENCE:      return FK_FENCE;
      OP_FENCE_I:    return FK_FENCE_I;
      OP_SFENCE_VMA: return FK_SFENCE;
      default:       return FK_NONE;
    endcase
  endfunction

  function automatic logic is_fence(fu_op op);
    return fence_kind(op) != FK_NONE;
  endfunction

endpackage

// File: rtl/commit_unit_pair_check.sv
// Decides whether the second-oldest entry may retire alongside the head in the same cycle.
// Only simple register-writing ops pair, and only behind a head that is itself simple.
module commit_pair_check
  import ariane_pkg::*;
(
  input  logic i_head_ack,
  input  fu_t  i_head_fu,
  input  fu_op i_head_op,
  input  logic i_head_ex_valid,
  input  logic i_next_valid,
  input  fu_t  i_next_fu,
  input  fu_op i_next_op,
  input  logic i_next_ex_valid,
  output logic o_next_ok
);

  logic w_head_serial;
  logic w_next_simple;

  assign w_head_serial = i_head_ex_valid || (i_head_fu inside {FU_STORE, FU_CSR})
                         || is_fence(i_head_op);
  assign w_next_simple = (i_next_fu inside {FU_ALU, FU_MULT, FU_CTRL_FLOW, FU_LOAD})
                         && !is_fence(i_next_op);
  assign o_next_ok     = i_head_ack && i_next_valid && !i_next_ex_valid
                         && w_next_simple && !w_head_serial;

endmodule

// File: rtl/commit_unit.sv
// In-order retirement of scoreboard head entries: register write-back, store release,
// CSR access, exception reporting and fence serialisation through an IDLE/DRAIN FSM.
module commit_unit
  import ariane_pkg::*;
#(
  parameter int NR_COMMIT_PORTS = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   flush_i,
  input  logic                                   halt_i,
  input  scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr_i,
  output logic [NR_COMMIT_PORTS-1:0]             commit_ack_o,
  output logic [NR_COMMIT_PORTS-1:0][4:0]        waddr_o,
  output logic [NR_COMMIT_PORTS-1:0][63:0]       wdata_o,
  output logic [NR_COMMIT_PORTS-1:0]             we_gpr_o,
  output logic [NR_COMMIT_PORTS-1:0]             we_fpr_o,
  output logic                                   commit_lsu_o,
  input  logic                                   commit_lsu_ready_i,
  input  logic                                   no_st_pending_i,
  output logic                                   csr_valid_o,
  output fu_op                                   csr_op_o,
  output logic [63:0]                            csr_wdata_o,
  input  logic [63:0]                            csr_rdata_i,
  input  exception_t                             csr_exception_i,
  output fence_kind_t                            fence_o,
  output exception_t                             exception_o,
  output logic [63:0]                            instret_o
);

  commit_state_e     r_state, w_state_next;
  exception_t        r_exception, w_ex_next;
  logic [63:0]       r_instret;
  scoreboard_entry_t w_head;
  logic              w_ack0, w_ack1, w_wb_ok0, w_retire_ok0;
  logic [1:0]        w_retire_cnt;

  assign w_head = commit_instr_i[0];

  always_comb begin
    w_state_next = r_state;
    w_ack0       = 1'b0;
    w_wb_ok0     = 1'b0;
    w_retire_ok0 = 1'b0;
    w_ex_next    = '0;
    commit_lsu_o = 1'b0;
    csr_valid_o  = 1'b0;
    csr_op_o     = OP_ADD;
    csr_wdata_o  = '0;
    fence_o      = FK_NONE;
    case (r_state)
      ST_IDLE: begin
        if (!halt_i && !flush_i && w_head.valid) begin
          if (w_head.ex.valid) begin
            w_ack0       = 1'b1;
            w_ex_next    = w_head.ex;
            w_ex_next.pc = w_head.pc;
          end else if (is_fence(w_head.op)) begin
            w_state_next = ST_DRAIN;
          end else if (w_head.fu == FU_STORE) begin
            commit_lsu_o = 1'b1;
            w_ack0       = commit_lsu_ready_i;
            w_retire_ok0 = commit_lsu_ready_i;
          end else if (w_head.fu == FU_CSR) begin
            csr_valid_o = 1'b1;
            csr_op_o    = w_head.op;
            csr_wdata_o = w_head.result;
            w_ack0      = 1'b1;
            if (csr_exception_i.valid) begin
              w_ex_next.valid = 1'b1;
              w_ex_next.cause = csr_exception_i.cause;
              w_ex_next.tval  = w_head.ex.tval;
              w_ex_next.pc    = w_head.pc;
            end else begin
              w_wb_ok0     = 1'b1;
              w_retire_ok0 = 1'b1;
            end
          end else begin
            w_ack0       = 1'b1;
            w_wb_ok0     = 1'b1;
            w_retire_ok0 = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // halt_i is deliberately ignored here: once serialising, the fence must complete
        if (flush_i) begin
          w_state_next = ST_IDLE;
        end else if (no_st_pending_i) begin
          w_ack0       = 1'b1;
          w_retire_ok0 = 1'b1;
          fence_o      = fence_kind(w_head.op);
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  generate
    if (NR_COMMIT_PORTS > 1) begin : g_pair
      commit_pair_check u_pair_check (
        .i_head_ack      (w_ack0),
        .i_head_fu       (w_head.fu),
        .i_head_op       (w_head.op),
        .i_head_ex_valid (w_head.ex.valid),
        .i_next_valid    (commit_instr_i[1].valid),
        .i_next_fu       (commit_instr_i[1].fu),
        .i_next_op       (commit_instr_i[1].op),
        .i_next_ex_valid (commit_instr_i[1].ex.valid),
        .o_next_ok       (w_ack1)
      );
    end else begin : g_single
      assign w_ack1 = 1'b0;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NR_COMMIT_PORTS; gi++) begin : g_wb
      logic w_wr;
      assign commit_ack_o[gi] = (gi == 0) ? w_ack0 : w_ack1;
      assign w_wr             = commit_ack_o[gi] && ((gi == 0) ? w_wb_ok0 : 1'b1);
      assign waddr_o[gi]      = commit_instr_i[gi].rd;
      assign wdata_o[gi]      = (gi == 0 && csr_valid_o) ? csr_rdata_i : commit_instr_i[gi].result;
      assign we_fpr_o[gi]     = w_wr && is_rd_fpr(commit_instr_i[gi].op);
      assign we_gpr_o[gi]     = w_wr && !is_rd_fpr(commit_instr_i[gi].op)
                                && (commit_instr_i[gi].rd != 5'd0);
    end
  endgenerate

  assign w_retire_cnt = {1'b0, w_retire_ok0} + {1'b0, w_ack1};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_exception <= '0;
      r_instret   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_exception <= w_ex_next;
      r_instret   <= r_instret + {62'd0, w_retire_cnt};
    end
  end

  assign exception_o = r_exception;
  assign instret_o   = r_instret;

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: a table of single-cycle retirement vectors followed by
// hand-written multi-cycle sequences for store stalls, fence draining, flush and reset.
module tb_commit_unit;
  import ariane_pkg::*;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic                    flush_i, halt_i;
  scoreboard_entry_t [1:0] commit_instr_i;
  logic [1:0]              commit_ack_o;
  logic [1:0][4:0]         waddr_o;
  logic [1:0][63:0]        wdata_o;
  logic [1:0]              we_gpr_o, we_fpr_o;
  logic                    commit_lsu_o, commit_lsu_ready_i, no_st_pending_i;
  logic                    csr_valid_o;
  fu_op                    csr_op_o;
  logic [63:0]             csr_wdata_o, csr_rdata_i;
  exception_t              csr_exception_i;
  fence_kind_t             fence_o;
  exception_t              exception_o;
  logic [63:0]             instret_o;

  always #5 clk_i = ~clk_i;

  commit_unit #(.NR_COMMIT_PORTS(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .halt_i(halt_i),
    .commit_instr_i(commit_instr_i), .commit_ack_o(commit_ack_o),
    .waddr_o(waddr_o), .wdata_o(wdata_o), .we_gpr_o(we_gpr_o), .we_fpr_o(we_fpr_o),
    .commit_lsu_o(commit_lsu_o), .commit_lsu_ready_i(commit_lsu_ready_i),
    .no_st_pending_i(no_st_pending_i), .csr_valid_o(csr_valid_o), .csr_op_o(csr_op_o),
    .csr_wdata_o(csr_wdata_o), .csr_rdata_i(csr_rdata_i), .csr_exception_i(csr_exception_i),
    .fence_o(fence_o), .exception_o(exception_o), .instret_o(instret_o)
  );

  typedef struct {
    scoreboard_entry_t e0, e1;
    logic        halt, flush, rdy;
    exception_t  cex;
    logic [1:0]  ack, gpr, fpr;
    logic        lsu, csrv;
    logic [63:0] wd0;
    int          delta;
    logic        exv;
    logic [63:0] cause;
  } vec_t;

  int          n_err = 0;
  int          n_chk = 0;
  logic [63:0] exp_instret = 0;
  vec_t        vecs[$];

  localparam logic [63:0] PC  = 64'h8000_0000;
  localparam logic [63:0] RDV = 64'hABCD;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic scoreboard_entry_t E(logic v, fu_t fu, fu_op op, logic [4:0] rd,
                                          logic [63:0] res, logic exv, logic [63:0] cause);
    scoreboard_entry_t e;
    e = '0;
    e.valid = v; e.fu = fu; e.op = op; e.rd = rd; e.result = res; e.pc = PC;
    e.ex.valid = exv; e.ex.cause = cause; e.ex.tval = 64'h77;
    return e;
  endfunction

  function automatic exception_t X(logic v, logic [63:0] cause);
    exception_t x;
    x = '0;
    x.valid = v; x.cause = cause;
    return x;
  endfunction

  function automatic vec_t V(scoreboard_entry_t e0, scoreboard_entry_t e1, logic halt, logic flush,
                             logic rdy, exception_t cex, logic [1:0] ack, logic [1:0] gpr,
                             logic [1:0] fpr, logic lsu, logic csrv, logic [63:0] wd0, int delta,
                             logic exv, logic [63:0] cause);
    vec_t v;
    v.e0 = e0; v.e1 = e1; v.halt = halt; v.flush = flush; v.rdy = rdy; v.cex = cex;
    v.ack = ack; v.gpr = gpr; v.fpr = fpr; v.lsu = lsu; v.csrv = csrv; v.wd0 = wd0;
    v.delta = delta; v.exv = exv; v.cause = cause;
    return v;
  endfunction

  task automatic set_in(input scoreboard_entry_t e0, input scoreboard_entry_t e1,
                        input logic halt, input logic flush, input logic rdy, input logic nost);
    commit_instr_i[0]  = e0;
    commit_instr_i[1]  = e1;
    halt_i             = halt;
    flush_i            = flush;
    commit_lsu_ready_i = rdy;
    no_st_pending_i    = nost;
  endtask

  task automatic seq_cyc(input string nm, input logic [1:0] ack, input fence_kind_t fk, input int delta);
    #1;
    chk({nm, "_ack"}, commit_ack_o, ack);
    chk({nm, "_fence"}, fence_o, fk);
    @(posedge clk_i); #1;
    exp_instret += 64'(delta);
    chk({nm, "_instret"}, instret_o, exp_instret);
    chk({nm, "_exv"}, exception_o.valid, 1'b0);
  endtask

  scoreboard_entry_t NOE;

  initial begin
    NOE = '0;
    rst_ni = 1'b0;
    set_in(NOE, NOE, 1'b0, 1'b0, 1'b0, 1'b0);
    csr_rdata_i = RDV;
    csr_exception_i = '0;

    vecs.push_back(V(E(1,FU_ALU,OP_ADD,5,64'h11,0,0), E(1,FU_ALU,OP_ADD,6,64'h22,0,0), 0,0,1, X(0,0), 2'b11,2'b11,2'b00,0,0,64'h11,2,0,0));
    vecs.push_back(V(E(1,FU_ALU,OP_ADD,0,64'h33,0,0), E(1,FU_MULT,OP_MUL,7,64'h44,0,0), 0,0,1, X(0,0), 2'b11,2'b10,2'b00,0,0,64'h33,2,0,0));
    vecs.push_back(V(E(1,FU_FPU,OP_FADD,3,64'h55,0,0), E(1,FU_CTRL_FLOW,OP_JAL,1,64'h66,0,0), 0,0,1, X(0,0), 2'b11,2'b10,2'b01,0,0,64'h55,2,0,0));
    vecs.push_back(V(E(1,FU_ALU,OP_ADD,4,64'h77,0,0), E(1,FU_FPU,OP_FMUL,2,64'h88,0,0), 0,0,1, X(0,0), 2'b01,2'b01,2'b00,0,0,64'h77,1,0,0));
    vecs.push_back(V(E(1,FU_LOAD,OP_LD,8,64'h99,1,5), E(1,FU_ALU,OP_ADD,9,64'h1,0,0), 0,0,1, X(0,0), 2'b01,2'b00,2'b00,0,0,64'h99,0,1,5));
    vecs.push_back(V(E(1,FU_ALU,OP_ADD,10,64'haa,0,0), E(1,FU_LOAD,OP_LD,11,64'h2,1,13), 0,0,1, X(0,0), 2'b01,2'b01,2'b00,0,0,64'haa,1,0,0));
    vecs.push_back(V(E(1,FU_ALU,OP_ADD,5,64'h11,0,0), E(1,FU_ALU,OP_ADD,6,64'h22,0,0), 1,0,1, X(0,0), 2'b00,2'b00,2'b00,0,0,64'h11,0,0,0));
    vecs.push_back(V(E(1,FU_ALU,OP_ADD,5,64'h11,0,0), E(1,FU_ALU,OP_ADD,6,64'h22,0,0), 0,1,1, X(0,0), 2'b00,2'b00,2'b00,0,0,64'h11,0,0,0));
    vecs.push_back(V(E(0,FU_ALU,OP_ADD,5,64'h11,0,0), E(1,FU_ALU,OP_ADD,6,64'h22,0,0), 0,0,1, X(0,0), 2'b00,2'b00,2'b00,0,0,64'h11,0,0,0));
    vecs.push_back(V(E(1,FU_STORE,OP_SD,0,64'hbb,0,0), E(1,FU_ALU,OP_ADD,12,64'hcc,0,0), 0,0,1, X(0,0), 2'b01,2'b00,2'b00,1,0,64'hbb,1,0,0));
    vecs.push_back(V(E(1,FU_STORE,OP_SD,0,64'hbb,0,0), E(1,FU_ALU,OP_ADD,12,64'hcc,0,0), 0,0,0, X(0,0), 2'b00,2'b00,2'b00,1,0,64'hbb,0,0,0));
    vecs.push_back(V(E(1,FU_CSR,OP_CSRRW,9,64'h55,0,0), E(1,FU_ALU,OP_ADD,1,64'h3,0,0), 0,0,1, X(0,0), 2'b01,2'b01,2'b00,0,1,RDV,1,0,0));
    vecs.push_back(V(E(1,FU_CSR,OP_CSRRS,9,64'h55,0,0), E(1,FU_ALU,OP_ADD,1,64'h3,0,0), 0,0,1, X(1,2), 2'b01,2'b00,2'b00,0,1,RDV,0,1,2));
    vecs.push_back(V(E(1,FU_LOAD,OP_FLD,0,64'h1,0,0), E(1,FU_MULT,OP_MUL,0,64'h2,0,0), 0,0,1, X(0,0), 2'b11,2'b00,2'b01,0,0,64'h1,2,0,0));
    vecs.push_back(V(E(1,FU_ALU,OP_SUB,13,64'h3,0,0), NOE, 0,0,1, X(0,0), 2'b01,2'b01,2'b00,0,0,64'h3,1,0,0));

    // reset state
    @(negedge clk_i); @(negedge clk_i);
    chk("rst_ack", commit_ack_o, 2'b00);
    chk("rst_instret", instret_o, 64'd0);
    chk("rst_exv", exception_o.valid, 1'b0);
    chk("rst_fence", fence_o, FK_NONE);
    chk("rst_lsu", commit_lsu_o, 1'b0);
    rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_i);
      set_in(vecs[i].e0, vecs[i].e1, vecs[i].halt, vecs[i].flush, vecs[i].rdy, 1'b1);
      csr_exception_i = vecs[i].cex;
      #1;
      chk($sformatf("v%0d_ack", i), commit_ack_o, vecs[i].ack);
      chk($sformatf("v%0d_we_gpr", i), we_gpr_o, vecs[i].gpr);
      chk($sformatf("v%0d_we_fpr", i), we_fpr_o, vecs[i].fpr);
      chk($sformatf("v%0d_lsu", i), commit_lsu_o, vecs[i].lsu);
      chk($sformatf("v%0d_csr_valid", i), csr_valid_o, vecs[i].csrv);
      chk($sformatf("v%0d_wdata0", i), wdata_o[0], vecs[i].wd0);
      chk($sformatf("v%0d_waddr1", i), waddr_o[1], 64'(vecs[i].e1.rd));
      @(posedge clk_i); #1;
      exp_instret += 64'(vecs[i].delta);
      chk($sformatf("v%0d_instret", i), instret_o, exp_instret);
      chk($sformatf("v%0d_exv", i), exception_o.valid, vecs[i].exv);
      if (vecs[i].exv) begin
        chk($sformatf("v%0d_cause", i), exception_o.cause, vecs[i].cause);
        chk($sformatf("v%0d_expc", i), exception_o.pc, PC);
      end
      $display("vector %0d ack=%b we_gpr=%b we_fpr=%b instret=%0d", i, vecs[i].ack, vecs[i].gpr, vecs[i].fpr, instret_o);
    end
    csr_exception_i = '0;

    // store held until the buffer accepts it
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      set_in(E(1,FU_STORE,OP_SD,0,64'hd0,0,0), NOE, 1'b0, 1'b0, c == 3, 1'b1);
      #1;
      chk($sformatf("st%0d_lsu", c), commit_lsu_o, 1'b1);
      seq_cyc($sformatf("st%0d", c), (c == 3) ? 2'b01 : 2'b00, FK_NONE, (c == 3) ? 1 : 0);
      $display("store cycle %0d ack=%b", c, (c == 3) ? 2'b01 : 2'b00);
    end

    // fence: enter DRAIN, wait 4 cycles for stores, complete even with halt raised
    for (int c = 0; c < 7; c++) begin
      @(negedge clk_i);
      if (c < 6) set_in(E(1,FU_CSR,OP_FENCE,0,64'h0,0,0), NOE, c == 5, 1'b0, 1'b1, c == 5);
      else       set_in(NOE, NOE, 1'b0, 1'b0, 1'b1, 1'b1);
      seq_cyc($sformatf("fence%0d", c), (c == 5) ? 2'b01 : 2'b00, (c == 5) ? FK_FENCE : FK_NONE, (c == 5) ? 1 : 0);
      $display("fence cycle %0d", c);
    end

    // flush in DRAIN returns to IDLE without acking
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      set_in(E(1,FU_CSR,OP_FENCE_I,0,64'h0,0,0), NOE, 1'b0, c == 1, 1'b1, c != 0);
      seq_cyc($sformatf("fl%0d", c), (c == 3) ? 2'b01 : 2'b00, (c == 3) ? FK_FENCE_I : FK_NONE, (c == 3) ? 1 : 0);
      $display("flush-drain cycle %0d", c);
    end

    // reset asserted mid-DRAIN
    @(negedge clk_i);
    set_in(E(1,FU_CSR,OP_SFENCE_VMA,0,64'h0,0,0), NOE, 1'b0, 1'b0, 1'b1, 1'b0);
    seq_cyc("rd_enter", 2'b00, FK_NONE, 0);
    @(negedge clk_i);
    no_st_pending_i = 1'b1;
    rst_ni = 1'b0;
    exp_instret = 0;
    #1;
    chk("rd_rst_ack", commit_ack_o, 2'b00);
    chk("rd_rst_fence", fence_o, FK_NONE);
    chk("rd_rst_instret", instret_o, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    seq_cyc("rd_idle", 2'b00, FK_NONE, 0);
    @(negedge clk_i);
    seq_cyc("rd_done", 2'b01, FK_SFENCE, 1);
    $display("reset-in-drain sequence done");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
